// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller: condition codes,
// NZCV bit positions and the controller FSM state encoding.
package branch_pkg;

  localparam logic [3:0] COND_AL = 4'b0000;
  localparam logic [3:0] COND_EQ = 4'b0001;
  localparam logic [3:0] COND_GT = 4'b0010;
  localparam logic [3:0] COND_LT = 4'b0011;
  localparam logic [3:0] COND_GE = 4'b0100;
  localparam logic [3:0] COND_LE = 4'b0101;
  localparam logic [3:0] COND_HI = 4'b0110;
  localparam logic [3:0] COND_CC = 4'b0111;
  localparam logic [3:0] COND_CS = 4'b1000;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch request channel from decode and redirect channel to fetch.
// Both channels: a transfer happens on a rising edge where valid & ready;
// valid and its payload stay stable until that edge, ready may toggle freely.
interface branch_ctrl_if;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [31:0] br_a;
  logic [31:0] br_b;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    output br_valid, br_cond, br_a, br_b, br_pc, br_offset, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_cond, br_a, br_b, br_pc, br_offset, redirect_ready,
    output br_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: unsigned operand compares and
// carry/zero flag tests; reserved codes behave as "always".
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0]  cond_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  nzcv_i,
  output logic        taken_o
);

  logic flag_z;
  logic flag_c;
  logic unused_nv;

  assign flag_z    = nzcv_i[NZCV_Z];
  assign flag_c    = nzcv_i[NZCV_C];
  assign unused_nv = nzcv_i[NZCV_N] ^ nzcv_i[NZCV_V];

  always_comb begin
    taken_o = 1'b1;
    case (cond_i)
      COND_AL: taken_o = 1'b1;
      COND_EQ: taken_o = (a_i == b_i);
      COND_GT: taken_o = (a_i > b_i);
      COND_LT: taken_o = (a_i < b_i);
      COND_GE: taken_o = (a_i >= b_i);
      COND_LE: taken_o = (a_i <= b_i);
      COND_HI: taken_o = flag_c & ~flag_z;
      COND_CC: taken_o = ~flag_c;
      COND_CS: taken_o = flag_c;
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures one branch, resolves it against the
// NZCV register, then sequences fetch redirect and pipeline flush if taken.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_ctrl_if.slave     bus,
  input  logic             flag_we,
  input  logic [3:0]       flag_nzcv,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt,
  output br_state_e        dbg_state
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  br_state_e        state_q;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [3:0]       cap_cond_q;
  logic [31:0]      cap_a_q;
  logic [31:0]      cap_b_q;
  logic [31:0]      cap_pc_q;
  logic [31:0]      cap_off_q;
  logic [3:0]       cap_nzcv_q;
  logic [3:0]       flush_cnt_q;
  logic             br_ready_q;
  logic             resolve_valid_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_q;
  logic             stall_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] resolved_cnt_q;
  logic             eval_taken;
  logic             accept;

  // A flag write landing in the acceptance cycle is what the branch must see.
  assign flags_d = flag_we ? flag_nzcv : flags_q;
  assign accept  = bus.br_valid & br_ready_q;

  branch_cond_eval u_cond_eval (
    .cond_i  (cap_cond_q),
    .a_i     (cap_a_q),
    .b_i     (cap_b_q),
    .nzcv_i  (cap_nzcv_q),
    .taken_o (eval_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      flags_q          <= 4'b0000;
      cap_cond_q       <= 4'b0000;
      cap_a_q          <= 32'd0;
      cap_b_q          <= 32'd0;
      cap_pc_q         <= 32'd0;
      cap_off_q        <= 32'd0;
      cap_nzcv_q       <= 4'b0000;
      flush_cnt_q      <= 4'd0;
      br_ready_q       <= 1'b1;
      resolve_valid_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      taken_cnt_q      <= '0;
      resolved_cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cap_cond_q      <= bus.br_cond;
            cap_a_q         <= bus.br_a;
            cap_b_q         <= bus.br_b;
            cap_pc_q        <= bus.br_pc;
            cap_off_q       <= bus.br_offset;
            cap_nzcv_q      <= flags_d;
            br_ready_q      <= 1'b0;
            stall_q         <= 1'b1;
            resolve_valid_q <= 1'b1;
            state_q         <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          resolve_valid_q <= 1'b0;
          resolved_cnt_q  <= resolved_cnt_q + CNT_W'(1);
          if (eval_taken) begin
            taken_cnt_q      <= taken_cnt_q + CNT_W'(1);
            redirect_pc_q    <= cap_pc_q + cap_off_q;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            state_q          <= ST_REDIRECT;
          end else begin
            br_ready_q <= 1'b1;
            stall_q    <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            flush_cnt_q      <= FLUSH_LOAD;
            if (FLUSH_CYCLES == 1) begin
              flush_q    <= 1'b0;
              stall_q    <= 1'b0;
              br_ready_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Counter holds the flush cycles still owed, including this one.
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
            stall_q     <= 1'b0;
            br_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.br_ready       = br_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign resolve_valid      = resolve_valid_q;
  assign resolve_taken      = resolve_valid_q & eval_taken;
  assign flush              = flush_q;
  assign stall              = stall_q;
  assign taken_cnt          = taken_cnt_q;
  assign resolved_cnt       = resolved_cnt_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: resolution timing, redirect backpressure,
// flag forwarding, target wrap, condition sweep and asynchronous reset.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int FC    = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             flag_we;
  logic [3:0]       flag_nzcv;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             stall;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] resolved_cnt;
  br_state_e        dbg_state;

  int tests_run = 0;
  int fails     = 0;
  int exp_resolved = 0;
  int exp_taken    = 0;

  branch_ctrl_if bus();

  branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flag_we       (flag_we),
    .flag_nzcv     (flag_nzcv),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .stall         (stall),
    .taken_cnt     (taken_cnt),
    .resolved_cnt  (resolved_cnt),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one branch for the acceptance cycle; returns #1 into cycle N+1.
  task automatic send_branch(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] off,
                             input logic fwe, input logic [3:0] fn);
    bus.br_valid  = 1'b1;
    bus.br_cond   = c;
    bus.br_a      = a;
    bus.br_b      = b;
    bus.br_pc     = pc;
    bus.br_offset = off;
    flag_we       = fwe;
    flag_nzcv     = fn;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    flag_we      = 1'b0;
  endtask

  // Called in cycle N+2 of a taken branch; accepts at once and waits out the flush.
  task automatic finish_redirect();
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    repeat (FC - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.br_ready !== 1'b1 || bus.redirect_valid !== 1'b0 || resolve_valid !== 1'b0 ||
        flush !== 1'b0 || stall !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b rv=%b res=%b flush=%b stall=%b state=%0d, want 1 0 0 0 0 0",
               bus.br_ready, bus.redirect_valid, resolve_valid, flush, stall, dbg_state);
    end
    tests_run++;
    if (taken_cnt !== 16'd0 || resolved_cnt !== 16'd0 || bus.redirect_pc !== 32'd0) begin
      fails++;
      $display("FAIL reset_regs: taken=%0d resolved=%0d pc=%h, want 0 0 0",
               taken_cnt, resolved_cnt, bus.redirect_pc);
    end
  endtask

  task automatic test_not_taken();
    send_branch(COND_EQ, 32'd5, 32'd6, 32'h200, 32'h40, 1'b0, 4'b0000);
    exp_resolved++;
    tests_run++;
    if (resolve_valid !== 1'b1 || resolve_taken !== 1'b0 || stall !== 1'b1 || bus.br_ready !== 1'b0) begin
      fails++;
      $display("FAIL not_taken_eval: res=%b taken=%b stall=%b ready=%b, want 1 0 1 0",
               resolve_valid, resolve_taken, stall, bus.br_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.br_ready !== 1'b1 || bus.redirect_valid !== 1'b0 || resolve_valid !== 1'b0 ||
        flush !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL not_taken_idle: ready=%b rv=%b res=%b flush=%b stall=%b, want 1 0 0 0 0",
               bus.br_ready, bus.redirect_valid, resolve_valid, flush, stall);
    end
    tests_run++;
    if (resolved_cnt !== 16'(exp_resolved) || taken_cnt !== 16'(exp_taken)) begin
      fails++;
      $display("FAIL not_taken_cnt: resolved=%0d taken=%0d, want %0d %0d",
               resolved_cnt, taken_cnt, exp_resolved, exp_taken);
    end
  endtask

  task automatic test_backpressure();
    send_branch(COND_GE, 32'h8000_0000, 32'h8000_0000, 32'h100, 32'hFFFF_FFF0, 1'b0, 4'b0000);
    exp_resolved++;
    exp_taken++;
    tests_run++;
    if (resolve_valid !== 1'b1 || resolve_taken !== 1'b1) begin
      fails++;
      $display("FAIL bp_eval: res=%b taken=%b, want 1 1", resolve_valid, resolve_taken);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_00F0 || flush !== 1'b1 ||
          stall !== 1'b1 || bus.br_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: rv=%b pc=%h flush=%b stall=%b ready=%b, want 1 000000f0 1 1 0",
                 i, bus.redirect_valid, bus.redirect_pc, flush, stall, bus.br_ready);
      end
      if (i == 3) bus.redirect_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    tests_run++;
    if (bus.redirect_valid !== 1'b0 || flush !== 1'b1 || stall !== 1'b1 || bus.br_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_flush: rv=%b flush=%b stall=%b ready=%b, want 0 1 1 0",
               bus.redirect_valid, flush, stall, bus.br_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (flush !== 1'b0 || stall !== 1'b0 || bus.br_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL bp_idle: flush=%b stall=%b ready=%b state=%0d, want 0 0 1 0",
               flush, stall, bus.br_ready, dbg_state);
    end
    tests_run++;
    if (resolved_cnt !== 16'(exp_resolved) || taken_cnt !== 16'(exp_taken)) begin
      fails++;
      $display("FAIL bp_cnt: resolved=%0d taken=%0d, want %0d %0d",
               resolved_cnt, taken_cnt, exp_resolved, exp_taken);
    end
  endtask

  task automatic test_flag_forward();
    send_branch(COND_HI, 32'd0, 32'd0, 32'h300, 32'h8, 1'b1, 4'b0010);
    exp_resolved++;
    exp_taken++;
    tests_run++;
    if (resolve_taken !== 1'b1) begin
      fails++;
      $display("FAIL fwd_hi_c: taken=%b, want 1", resolve_taken);
    end
    @(posedge clk); #1;
    finish_redirect();
    send_branch(COND_HI, 32'd0, 32'd0, 32'h300, 32'h8, 1'b1, 4'b0110);
    exp_resolved++;
    tests_run++;
    if (resolve_valid !== 1'b1 || resolve_taken !== 1'b0) begin
      fails++;
      $display("FAIL fwd_hi_z: res=%b taken=%b, want 1 0", resolve_valid, resolve_taken);
    end
    @(posedge clk); #1;
    // Flags now 0110 (C set); a write during EVAL must not change the outcome.
    send_branch(COND_CS, 32'd0, 32'd0, 32'h400, 32'h4, 1'b0, 4'b0000);
    flag_we   = 1'b1;
    flag_nzcv = 4'b0000;
    exp_resolved++;
    exp_taken++;
    tests_run++;
    if (resolve_taken !== 1'b1) begin
      fails++;
      $display("FAIL late_flag_write: taken=%b, want 1", resolve_taken);
    end
    @(posedge clk); #1;
    flag_we = 1'b0;
    tests_run++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h404) begin
      fails++;
      $display("FAIL late_flag_redirect: rv=%b pc=%h, want 1 00000404", bus.redirect_valid, bus.redirect_pc);
    end
    finish_redirect();
  endtask

  task automatic test_target_wrap();
    send_branch(COND_AL, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h10, 1'b0, 4'b0000);
    exp_resolved++;
    exp_taken++;
    @(posedge clk); #1;
    tests_run++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_0008) begin
      fails++;
      $display("FAIL target_wrap: rv=%b pc=%h, want 1 00000008", bus.redirect_valid, bus.redirect_pc);
    end
    finish_redirect();
  endtask

  task automatic test_code_sweep();
    logic [3:0]  codes [6];
    logic [31:0] av    [6];
    logic [31:0] bv    [6];
    logic        exp_t [6];
    codes = '{COND_GT, COND_LT, COND_LE, COND_EQ, COND_CC, COND_CS};
    av    = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h1234_5678, 32'd0, 32'd0};
    bv    = '{32'd1, 32'd1, 32'd3, 32'h1234_5679, 32'd0, 32'd0};
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Flags are 0000 from the late write in the forwarding test.
    for (int i = 0; i < 6; i++) begin
      send_branch(codes[i], av[i], bv[i], 32'h1000, 32'h20, 1'b0, 4'b0000);
      exp_resolved++;
      if (exp_t[i]) exp_taken++;
      tests_run++;
      if (resolve_taken !== exp_t[i]) begin
        fails++;
        $display("FAIL cond_%0d: taken=%b, want %b", codes[i], resolve_taken, exp_t[i]);
      end
      @(posedge clk); #1;
      if (exp_t[i]) finish_redirect();
    end
    for (int c = 9; c < 16; c++) begin
      send_branch(4'(c), 32'd7, 32'd9, 32'h2000, 32'h4, 1'b0, 4'b0000);
      exp_resolved++;
      exp_taken++;
      tests_run++;
      if (resolve_taken !== 1'b1) begin
        fails++;
        $display("FAIL reserved_%0d: taken=%b, want 1", c, resolve_taken);
      end
      @(posedge clk); #1;
      finish_redirect();
    end
    tests_run++;
    if (resolved_cnt !== 16'(exp_resolved) || taken_cnt !== 16'(exp_taken)) begin
      fails++;
      $display("FAIL sweep_cnt: resolved=%0d taken=%0d, want %0d %0d",
               resolved_cnt, taken_cnt, exp_resolved, exp_taken);
    end
  endtask

  task automatic test_reset_mid();
    send_branch(COND_AL, 32'd0, 32'd0, 32'h40, 32'h20, 1'b1, 4'b1111);
    @(posedge clk); #1;
    tests_run++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h60) begin
      fails++;
      $display("FAIL pre_reset_redirect: rv=%b pc=%h, want 1 00000060", bus.redirect_valid, bus.redirect_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.redirect_valid !== 1'b0 || flush !== 1'b0 || stall !== 1'b0 || bus.br_ready !== 1'b1 ||
        resolve_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL async_reset: rv=%b flush=%b stall=%b ready=%b res=%b state=%0d, want 0 0 0 1 0 0",
               bus.redirect_valid, flush, stall, bus.br_ready, resolve_valid, dbg_state);
    end
    tests_run++;
    if (taken_cnt !== 16'd0 || resolved_cnt !== 16'd0 || bus.redirect_pc !== 32'd0) begin
      fails++;
      $display("FAIL async_reset_regs: taken=%0d resolved=%0d pc=%h, want 0 0 0",
               taken_cnt, resolved_cnt, bus.redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_resolved = 0;
    exp_taken    = 0;
    tests_run++;
    if (bus.br_ready !== 1'b1 || taken_cnt !== 16'd0 || resolved_cnt !== 16'd0) begin
      fails++;
      $display("FAIL post_reset: ready=%b taken=%0d resolved=%0d, want 1 0 0",
               bus.br_ready, taken_cnt, resolved_cnt);
    end
    send_branch(COND_HI, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 4'b0000);
    exp_resolved++;
    tests_run++;
    if (resolve_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags_hi: taken=%b, want 0", resolve_taken);
    end
    @(posedge clk); #1;
    send_branch(COND_CC, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 4'b0000);
    exp_resolved++;
    exp_taken++;
    tests_run++;
    if (resolve_taken !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags_cc: taken=%b, want 1", resolve_taken);
    end
    @(posedge clk); #1;
    finish_redirect();
    tests_run++;
    if (resolved_cnt !== 16'(exp_resolved) || taken_cnt !== 16'(exp_taken) || bus.br_ready !== 1'b1) begin
      fails++;
      $display("FAIL final_cnt: resolved=%0d taken=%0d ready=%b, want %0d %0d 1",
               resolved_cnt, taken_cnt, bus.br_ready, exp_resolved, exp_taken);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    flag_we            = 1'b0;
    flag_nzcv          = 4'b0000;
    bus.br_valid       = 1'b0;
    bus.br_cond        = 4'b0000;
    bus.br_a           = 32'd0;
    bus.br_b           = 32'd0;
    bus.br_pc          = 32'd0;
    bus.br_offset      = 32'd0;
    bus.redirect_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_not_taken();
    test_backpressure();
    test_flag_forward();
    test_target_wrap();
    test_code_sweep();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
